// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped write-back data cache.
// Sizes come from the DRAM/DCACHE macros when the build defines them.
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif
`ifndef DCACHE_INDEX
`define DCACHE_INDEX 4
`endif

package dcache_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int WORD_SIZE   = `DRAM_WORD_SIZE;
    localparam int BLOCK_SIZE  = `DRAM_BLOCK_SIZE;
    localparam int INDEX_BITS  = `DCACHE_INDEX;
    localparam int NUM_LINES   = 2 ** INDEX_BITS;
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int OFFSET_LSB  = 2;
    localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;
    localparam int TAG_LSB     = INDEX_LSB + INDEX_BITS;
    localparam int TAG_BITS    = ADDR_WIDTH - TAG_LSB;

    typedef logic [WORD_SIZE-1:0]   word_t;
    typedef word_t [BLOCK_SIZE-1:0] block_t;
    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;
endpackage

// File: rtl/dcache_if.sv
// CPU, data-SRAM and DRAM signal bundle of the data cache controller.
// master = the controller, slave = the pipeline/SRAM/DRAM surroundings.
interface dcache_if;
    import dcache_pkg::*;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    word_t                 cpu_wdata;
    word_t                 cpu_rdata;
    logic                  cpu_ready;
    index_t                sram_index;
    logic                  sram_we;
    block_t                sram_wdata;
    block_t                sram_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    block_t                mem_wdata;
    block_t                mem_rdata;
    logic                  mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, sram_index, sram_we, sram_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, sram_index, sram_we, sram_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_tag_store.sv
// Tag, valid and dirty arrays: asynchronous read of one line, synchronous update.
// Tags are not reset; a line is only trusted once its valid bit is set by a fill.
module dcache_tag_store
    import dcache_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  index_t i_index,
    input  logic   i_fill,
    input  tag_t   i_fillTag,
    input  logic   i_setDirty,
    input  logic   i_clrDirty,
    output tag_t   o_tag,
    output logic   o_valid,
    output logic   o_dirty
);
    tag_t                 r_tag [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_tag[i_index]   <= i_fillTag;
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_setDirty) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clrDirty) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-allocate write-back data cache sequencer.
// Hits complete combinationally in IDLE; misses run writeback/allocate over the DRAM port.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic clock,
    input  logic reset,
    dcache_if.master bus
);
    state_t                r_state;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    block_t                r_memWdata;

    tag_t    w_reqTag;
    tag_t    w_storedTag;
    index_t  w_index;
    offset_t w_offset;
    logic    w_valid;
    logic    w_dirty;
    logic    w_hit;
    logic    w_ackSeen;
    logic    w_fill;
    logic    w_setDirty;
    logic    w_clrDirty;
    logic    w_cpuReady;
    word_t   w_cpuRdata;
    logic    w_sramWe;
    block_t  w_sramWdata;
    block_t  w_merged;

    assign w_reqTag  = bus.cpu_addr[ADDR_WIDTH-1:TAG_LSB];
    assign w_index   = bus.cpu_addr[TAG_LSB-1:INDEX_LSB];
    assign w_offset  = bus.cpu_addr[INDEX_LSB-1:OFFSET_LSB];
    assign w_hit     = w_valid && (w_storedTag == w_reqTag);
    assign w_ackSeen = bus.mem_ack && r_memReq;

    dcache_tag_store u_tagStore (
        .clock      (clock),
        .reset      (reset),
        .i_index    (w_index),
        .i_fill     (w_fill),
        .i_fillTag  (w_reqTag),
        .i_setDirty (w_setDirty),
        .i_clrDirty (w_clrDirty),
        .o_tag      (w_storedTag),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty)
    );

    always_comb begin
        w_merged           = bus.sram_rdata;
        w_merged[w_offset] = bus.cpu_wdata;
    end

    // Same-cycle responses; gated by reset so a stale ack or hit cannot touch the SRAM.
    always_comb begin
        w_cpuReady  = 1'b0;
        w_cpuRdata  = '0;
        w_sramWe    = 1'b0;
        w_sramWdata = '0;
        w_fill      = 1'b0;
        w_setDirty  = 1'b0;
        w_clrDirty  = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req && w_hit) begin
                        w_cpuReady = 1'b1;
                        if (bus.cpu_we) begin
                            w_sramWe    = 1'b1;
                            w_sramWdata = w_merged;
                            w_setDirty  = 1'b1;
                        end else begin
                            w_cpuRdata = bus.sram_rdata[w_offset];
                        end
                    end
                end
                WRITEBACK: w_clrDirty = w_ackSeen;
                ALLOCATE: begin
                    if (w_ackSeen) begin
                        w_sramWe    = 1'b1;
                        w_sramWdata = bus.mem_rdata;
                        w_fill      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The DRAM request is registered so it stays stable until acknowledged.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req && !w_hit) begin
                        r_memReq <= 1'b1;
                        if (w_valid && w_dirty) begin
                            r_state    <= WRITEBACK;
                            r_memWe    <= 1'b1;
                            r_memAddr  <= {w_storedTag, w_index, {INDEX_LSB{1'b0}}};
                            r_memWdata <= bus.sram_rdata;
                        end else begin
                            r_state   <= ALLOCATE;
                            r_memWe   <= 1'b0;
                            r_memAddr <= {w_reqTag, w_index, {INDEX_LSB{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (w_ackSeen) begin
                        r_state   <= ALLOCATE;
                        r_memReq  <= 1'b0;
                        r_memWe   <= 1'b0;
                        r_memAddr <= {w_reqTag, w_index, {INDEX_LSB{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (w_ackSeen) begin
                        r_state  <= IDLE;
                        r_memReq <= 1'b0;
                    end else if (!r_memReq) begin
                        r_memReq <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready  = w_cpuReady;
    assign bus.cpu_rdata  = w_cpuRdata;
    assign bus.sram_index = w_index;
    assign bus.sram_we    = w_sramWe;
    assign bus.sram_wdata = w_sramWdata;
    assign bus.mem_req    = r_memReq;
    assign bus.mem_we     = r_memWe;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_wdata  = r_memWdata;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with behavioural SRAM and DRAM models.
// Unwritten DRAM block at byte address a holds word i = 0x1000_0000 | (a[15:0] << 4) | i.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dcache_if bus ();

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    block_t sramMem [NUM_LINES];
    block_t dram [int unsigned];
    int     sramWeCount = 0;

    assign bus.sram_rdata = sramMem[bus.sram_index];

    always @(posedge clock) begin
        if (bus.sram_we) begin
            sramMem[bus.sram_index] <= bus.sram_wdata;
            sramWeCount <= sramWeCount + 1;
        end
    end

    // Protocol rules that must hold on every active edge outside reset.
    always @(posedge clock) begin
        if (!reset && dut.r_state != IDLE) begin
            assert (bus.cpu_req) else $error("[TB] cpu_req dropped mid-miss");
            assert (!bus.cpu_ready) else $error("[TB] cpu_ready outside IDLE");
        end
    end

    // Per-access log of DRAM transactions as seen on the bus.
    logic        txnWe    [8];
    logic [31:0] txnAddr  [8];
    block_t      txnData  [8];
    int          txnStart [8];
    int          txnCount;
    int          stableErr;

    function automatic block_t dramRead(input logic [31:0] a);
        block_t b;
        if (dram.exists(a)) return dram[a];
        for (int i = 0; i < BLOCK_SIZE; i++)
            b[i] = 32'h1000_0000 | ({16'h0, a[15:0]} << 4) | i;
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one load/store and services DRAM with a fixed ack delay; called just after a negedge.
    task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                 input int ackDelay, output int cycles, output logic [31:0] rdata);
        int  reqLen = 0;
        bit  done = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        txnCount  = 0;
        stableErr = 0;
        cycles    = 0;
        rdata     = '0;
        while (!done && cycles < 200) begin
            bus.mem_ack = 1'b0;
            #1;
            if (bus.cpu_ready) begin
                rdata = bus.cpu_rdata;
                done  = 1;
            end else if (bus.mem_req) begin
                if (reqLen == 0) begin
                    if (txnCount < 8) begin
                        txnWe[txnCount]    = bus.mem_we;
                        txnAddr[txnCount]  = bus.mem_addr;
                        txnData[txnCount]  = bus.mem_wdata;
                        txnStart[txnCount] = cycles;
                    end
                    txnCount++;
                end else if (txnCount <= 8) begin
                    if (bus.mem_we !== txnWe[txnCount-1] || bus.mem_addr !== txnAddr[txnCount-1] ||
                        (bus.mem_we && bus.mem_wdata !== txnData[txnCount-1]))
                        stableErr++;
                end
                reqLen++;
                if (reqLen == ackDelay) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        dram[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = '0;
                    end else begin
                        bus.mem_rdata = dramRead(bus.mem_addr);
                    end
                    reqLen = 0;
                end
            end else begin
                reqLen = 0;
            end
            if (!done) begin
                @(negedge clock);
                cycles++;
            end
        end
        if (!done) checkOutput("timeout", 1, 0);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    int          cyc;
    logic [31:0] rd;
    int          weBefore;

    initial begin
        for (int i = 0; i < NUM_LINES; i++) sramMem[i] = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rstReady", bus.cpu_ready, 0);
        checkOutput("rstMemReq", bus.mem_req, 0);
        checkOutput("rstMemWe", bus.mem_we, 0);
        checkOutput("rstSramWe", bus.sram_we, 0);
        checkOutput("rstMemAddr", bus.mem_addr, 0);
        checkOutput("rstRdata", bus.cpu_rdata, 0);
        @(negedge clock);

        // Cold load: one fetch of 0x40, clean-miss latency L+1.
        applyStimulus(32'h40, 1'b0, 32'h0, 2, cyc, rd);
        checkOutput("coldCycles", cyc, 3);
        checkOutput("coldRdata", rd, 32'h1000_0400);
        checkOutput("coldTxns", txnCount, 1);
        checkOutput("coldWe", txnWe[0], 0);
        checkOutput("coldAddr", txnAddr[0], 32'h40);

        applyStimulus(32'h48, 1'b0, 32'h0, 1, cyc, rd);
        checkOutput("hitCycles", cyc, 0);
        checkOutput("hitRdata", rd, 32'h1000_0402);
        checkOutput("hitTxns", txnCount, 0);

        // Store hit, then a conflicting load forces a dirty writeback.
        applyStimulus(32'h44, 1'b1, 32'hDEAD_BEEF, 1, cyc, rd);
        checkOutput("stCycles", cyc, 0);
        checkOutput("stSram", sramMem[4],
                    {32'h1000_0403, 32'h1000_0402, 32'hDEAD_BEEF, 32'h1000_0400});
        applyStimulus(32'h144, 1'b0, 32'h0, 2, cyc, rd);
        checkOutput("dirtyTxns", txnCount, 2);
        checkOutput("wbWe", txnWe[0], 1);
        checkOutput("wbAddr", txnAddr[0], 32'h40);
        checkOutput("wbData", txnData[0],
                    {32'h1000_0403, 32'h1000_0402, 32'hDEAD_BEEF, 32'h1000_0400});
        checkOutput("allocWe", txnWe[1], 0);
        checkOutput("allocAddr", txnAddr[1], 32'h140);
        checkOutput("dirtyRdata", rd, 32'h1000_1401);

        applyStimulus(32'h44, 1'b0, 32'h0, 1, cyc, rd);
        checkOutput("refetchTxns", txnCount, 1);
        checkOutput("refetchRdata", rd, 32'hDEAD_BEEF);

        // Clean conflict: single fetch, no writeback.
        applyStimulus(32'h80, 1'b0, 32'h0, 1, cyc, rd);
        checkOutput("l80Cycles", cyc, 2);
        checkOutput("l80Rdata", rd, 32'h1000_0800);
        applyStimulus(32'h180, 1'b0, 32'h0, 1, cyc, rd);
        checkOutput("cleanTxns", txnCount, 1);
        checkOutput("cleanWe", txnWe[0], 0);
        checkOutput("cleanAddr", txnAddr[0], 32'h180);
        checkOutput("cleanRdata", rd, 32'h1000_1800);

        // Slow writeback ack: request must hold steady for all 5 cycles.
        applyStimulus(32'h184, 1'b1, 32'h1234_5678, 1, cyc, rd);
        checkOutput("st184Cycles", cyc, 0);
        applyStimulus(32'h84, 1'b0, 32'h0, 5, cyc, rd);
        checkOutput("slowTxns", txnCount, 2);
        checkOutput("slowWbAddr", txnAddr[0], 32'h180);
        checkOutput("slowWbData", txnData[0],
                    {32'h1000_1803, 32'h1000_1802, 32'h1234_5678, 32'h1000_1800});
        checkOutput("slowStable", stableErr, 0);
        checkOutput("slowGap", (txnStart[1] - txnStart[0] - 5) >= 1, 1);
        checkOutput("slowAllocAddr", txnAddr[1], 32'h80);
        checkOutput("slowRdata", rd, 32'h1000_0801);

        // Reset in ALLOCATE followed by a stale ack.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h2C0;
        @(negedge clock);
        #1;
        checkOutput("abortReq", bus.mem_req, 1);
        checkOutput("abortWe", bus.mem_we, 0);
        checkOutput("abortAddr", bus.mem_addr, 32'h2C0);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abortReqDrop", bus.mem_req, 0);
        weBefore = sramWeCount;
        @(negedge clock);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = dramRead(32'h2C0);
        #1;
        checkOutput("staleSramWe", bus.sram_we, 0);
        @(negedge clock);
        bus.mem_ack = 1'b0;
        #1;
        checkOutput("staleMemReq", bus.mem_req, 0);
        checkOutput("staleWeCount", sramWeCount, weBefore);
        @(negedge clock);
        applyStimulus(32'h40, 1'b0, 32'h0, 1, cyc, rd);
        checkOutput("postRstTxns", txnCount, 1);
        checkOutput("postRstCycles", cyc, 2);
        checkOutput("postRstRdata", rd, 32'h1000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
